// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-chain sequencers.
//   state_t   : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
//   cnt_width : bit-counter width for a given word length, ceil(log2(width))
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_bit_down_counter.sv
// Loadable down counter used to index the bits of a shift pass.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   count    : current count
//   zero     : high when count is zero
module bit_down_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a serial-in/serial-out shift chain. On an accepted START it
// drives the chain's serial input MSB first with shift enable for exactly
// WIDTH cycles, while capturing the bits leaving the chain's last stage, so
// each pass swaps a new word in and reads the old word out.
// Ports:
//   CLK      : rising-edge clock
//   CLR      : asynchronous active-high reset
//   START    : request a pass (sampled in IDLE only)
//   ABORT    : cancel a pass (sampled in SHIFT); blocks START in IDLE
//   DIN      : word to shift in, latched on accepted START
//   SO       : serial output of the chain's last stage
//   SHIFT_EN : registered chain shift enable
//   SER_IN   : registered serial data to the chain, 0 when not shifting
//   BUSY     : high in SHIFT and DONE
//   DONE     : one-cycle pulse on normal completion
//   DOUT     : old chain contents from the last completed pass
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SO,
  output logic             SHIFT_EN,
  output logic             SER_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DOUT
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   load_q;
  logic [WIDTH-1:0]   capt_q;
  logic [WIDTH-1:0]   capt_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_m1;
  logic               cnt_zero;
  logic               cnt_load;
  logic               cnt_dec;
  logic               load_en;
  logic               dout_en;
  logic               shift_en_d;
  logic               ser_in_d;

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (CLR),
    .load     (cnt_load),
    .load_val (CNT_W'(WIDTH - 1)),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign cnt_m1   = cnt - CNT_W'(1);
  // SO is sampled before the chain moves, so the captured value includes
  // the bit present at this edge.
  assign capt_nxt = {capt_q[WIDTH-2:0], SO};

  // SHIFT_EN/SER_IN are registered, so the comb block computes the values
  // for the cycle after the edge: the bit for the next cycle is load[cnt-1].
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    load_en    = 1'b0;
    dout_en    = 1'b0;
    shift_en_d = 1'b0;
    ser_in_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          state_d    = ST_SHIFT;
          load_en    = 1'b1;
          cnt_load   = 1'b1;
          shift_en_d = 1'b1;
          ser_in_d   = DIN[WIDTH-1];
        end
      end
      ST_SHIFT: begin
        cnt_dec = !cnt_zero;
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
          dout_en = 1'b1;
        end else begin
          shift_en_d = 1'b1;
          ser_in_d   = load_q[cnt_m1];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      SHIFT_EN <= 1'b0;
      SER_IN   <= 1'b0;
      load_q   <= '0;
      capt_q   <= '0;
      DOUT     <= '0;
    end else begin
      state_q  <= state_d;
      SHIFT_EN <= shift_en_d;
      SER_IN   <= ser_in_d;
      if (load_en) begin
        load_q <= DIN;
      end
      if (SHIFT_EN) begin
        capt_q <= capt_nxt;
      end
      if (dout_en) begin
        DOUT <= capt_nxt;
      end
    end
  end

  assign BUSY = (state_q != ST_IDLE);
  assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] din = '0;

  logic        se4, si4, busy4, done4;
  logic [3:0]  dout4;
  logic        se8, si8, busy8, done8;
  logic [7:0]  dout8;
  logic        so4, so8;

  // Environment: the physical shift chains (index 0 = 4-bit, 1 = 8-bit).
  logic [31:0] chain [2];
  // Reference model: phase 0 idle, 1..w shifting, w+1 done.
  int          ph    [2];
  logic [31:0] ld    [2];
  logic [31:0] old   [2];
  logic [31:0] dm    [2];
  int          wd    [2] = '{4, 8};

  int          passes = 0;
  int          total  = 0;
  int          se4_cnt, se8_cnt;

  assign so4 = chain[0][3];
  assign so8 = chain[1][7];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4)) u4 (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort), .DIN(din[3:0]), .SO(so4),
    .SHIFT_EN(se4), .SER_IN(si4), .BUSY(busy4), .DONE(done4), .DOUT(dout4)
  );

  shift_seq_ctrl #(.WIDTH(8)) u8 (
    .CLK(clk), .CLR(clr), .START(start), .ABORT(abort), .DIN(din[7:0]), .SO(so8),
    .SHIFT_EN(se8), .SER_IN(si8), .BUSY(busy8), .DONE(done8), .DOUT(dout8)
  );

  function automatic logic [31:0] msk(input int w);
    return (32'h1 << w) - 32'h1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_se, e_si;
    for (int d = 0; d < 2; d++) begin
      e_se = (ph[d] >= 1 && ph[d] <= wd[d]) ? 32'd1 : 32'd0;
      e_si = (e_se != 0) ? ((ld[d] >> (wd[d] - ph[d])) & 32'd1) : 32'd0;
      if (d == 0) begin
        chk({tag, ".se4"},   {31'd0, se4},   e_se);
        chk({tag, ".si4"},   {31'd0, si4},   e_si);
        chk({tag, ".busy4"}, {31'd0, busy4}, (ph[0] != 0) ? 32'd1 : 32'd0);
        chk({tag, ".done4"}, {31'd0, done4}, (ph[0] == 5) ? 32'd1 : 32'd0);
        chk({tag, ".dout4"}, {28'd0, dout4}, dm[0]);
      end else begin
        chk({tag, ".se8"},   {31'd0, se8},   e_se);
        chk({tag, ".si8"},   {31'd0, si8},   e_si);
        chk({tag, ".busy8"}, {31'd0, busy8}, (ph[1] != 0) ? 32'd1 : 32'd0);
        chk({tag, ".done8"}, {31'd0, done8}, (ph[1] == 9) ? 32'd1 : 32'd0);
        chk({tag, ".dout8"}, {24'd0, dout8}, dm[1]);
      end
    end
  endtask

  task automatic model_clr();
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; ld[d] = '0; old[d] = '0; dm[d] = '0; chain[d] = '0;
    end
  endtask

  // One clock: model and chains advance on the edge, outputs checked at +1.
  task automatic step(input string tag);
    logic s0, i0, s1, i1;
    int   w;
    s0 = se4; i0 = si4; s1 = se8; i1 = si8;
    @(posedge clk);
    #1;
    if (s0) se4_cnt++;
    if (s1) se8_cnt++;
    for (int d = 0; d < 2; d++) begin
      w = wd[d];
      if (ph[d] == 0) begin
        if (start && !abort) begin
          ph[d]  = 1;
          ld[d]  = din & msk(w);
          old[d] = chain[d];
        end
      end else if (ph[d] <= w) begin
        if (abort) ph[d] = 0;
        else if (ph[d] == w) begin
          ph[d] = w + 1;
          dm[d] = old[d];
        end else ph[d]++;
      end else begin
        ph[d] = 0;
      end
    end
    if (s0) chain[0] = ((chain[0] << 1) | {31'd0, i0}) & msk(4);
    if (s1) chain[1] = ((chain[1] << 1) | {31'd0, i1}) & msk(8);
    check_all(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((ph[0] != 0 || ph[1] != 0) && n < 40) begin
      step(tag);
      n++;
    end
    if (n >= 40) chk({tag, ".timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_pass(input string tag, input logic [31:0] d);
    se4_cnt = 0; se8_cnt = 0;
    din = d; start = 1'b1;
    step(tag);
    start = 1'b0;
    wait_idle(tag);
    step(tag);
  endtask

  // Asynchronous clear between edges; outputs must drop at once.
  task automatic do_clr(input string tag);
    #2 clr = 1'b1;
    #1;
    model_clr();
    check_all(tag);
    #1 clr = 1'b0;
  endtask

  initial begin
    model_clr();
    #1 clr = 1'b1;
    #2;
    check_all("reset");
    #5 clr = 1'b0;

    // 1: first pass into a cleared chain
    run_pass("t1", 32'hB);
    chk("t1.se4_cycles", se4_cnt, 4);
    chk("t1.dout4", {28'd0, dout4}, 32'h0);
    chk("t1.chain4", chain[0], 32'hB);

    // 2: START held through SHIFT and DONE is not queued
    se4_cnt = 0;
    din = 32'h6; start = 1'b1;
    repeat (5) step("t2");
    start = 1'b0;
    wait_idle("t2");
    step("t2");
    chk("t2.se4_cycles", se4_cnt, 4);
    chk("t2.dout4", {28'd0, dout4}, 32'hB);
    chk("t2.chain4", chain[0], 32'h6);

    // 3: ABORT in the second SHIFT cycle
    din = 32'h9; start = 1'b1;
    step("t3");
    start = 1'b0;
    step("t3");
    abort = 1'b1;
    step("t3");
    abort = 1'b0;
    step("t3");
    chk("t3.busy4", {31'd0, busy4}, 32'd0);
    chk("t3.dout4", {28'd0, dout4}, 32'hB);
    run_pass("t3b", 32'h3);

    // 4: CLR mid-pass, then a clean pass
    din = 32'hC; start = 1'b1;
    step("t4");
    start = 1'b0;
    step("t4");
    do_clr("t4.clr");
    run_pass("t4b", 32'hF);
    chk("t4.dout4", {28'd0, dout4}, 32'h0);

    // 5: START and ABORT together in IDLE
    start = 1'b1; abort = 1'b1;
    step("t5");
    step("t5");
    start = 1'b0; abort = 1'b0;
    chk("t5.busy4", {31'd0, busy4}, 32'd0);

    // 6: 8-bit chain preloaded with 3C, then A5
    run_pass("t6a", 32'h3C);
    run_pass("t6b", 32'hA5);
    chk("t6.se8_cycles", se8_cnt, 8);
    chk("t6.dout8", {24'd0, dout8}, 32'h3C);
    chk("t6.chain8", chain[1], 32'hA5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      din   = $urandom;
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 15) == 0);
      step("rnd");
      if ($urandom_range(0, 99) == 0) do_clr("rnd.clr");
    end
    start = 1'b0; abort = 1'b0;
    wait_idle("end");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
